// File: rtl/fifo_pkg.sv
// Shared constants, flag bundle and helper functions for the synchronous FIFO controller.
// The default depth and levels are also used where the buffer memory is instantiated.
package fifo_pkg;

  localparam int DEFAULT_DEPTH     = 100;
  localparam int DEFAULT_AF_MARGIN = 4;
  localparam int DEFAULT_AE_LEVEL  = 4;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // Width needed to hold an occupancy of 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Advance a pointer, wrapping at depth-1 so that non-power-of-two depths work.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Buffer pointer register: advances on i_adv, wraps at SIZE_DEPTH-1, cleared by reset or i_clr.
module fifo_ptr_wrap
  import fifo_pkg::*;
#(
  parameter int SIZE_DEPTH = DEFAULT_DEPTH,
  parameter int SIZE_ADDR  = $clog2(SIZE_DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic                 i_adv,
  output logic [SIZE_ADDR-1:0] o_ptr
);

  logic [SIZE_ADDR-1:0] ptr_q;
  logic [SIZE_ADDR-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (i_clr) begin
      ptr_d = '0;
    end else if (i_adv) begin
      ptr_d = SIZE_ADDR'(ptr_next(32'(ptr_q), SIZE_DEPTH));
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign o_ptr = ptr_q;

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller: sequences an external dual-port buffer and
// keeps occupancy, level flags, read-valid strobe and sticky error flags.
module fifo_sync_ctrl
  import fifo_pkg::*;
#(
  parameter int SIZE_DEPTH = DEFAULT_DEPTH,
  parameter int SIZE_ADDR  = $clog2(SIZE_DEPTH),
  parameter int SIZE_CNT   = cnt_width(SIZE_DEPTH),
  parameter int AF_LEVEL   = SIZE_DEPTH - DEFAULT_AF_MARGIN,
  parameter int AE_LEVEL   = DEFAULT_AE_LEVEL
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_wr_en,
  input  logic                 i_rd_en,
  input  logic                 i_clr,
  output logic                 o_mem_wr_en,
  output logic [SIZE_ADDR-1:0] o_mem_addr_wr,
  output logic                 o_mem_rd_en,
  output logic [SIZE_ADDR-1:0] o_mem_addr_rd,
  output logic                 o_rd_valid,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_almost_full,
  output logic                 o_almost_empty,
  output logic [SIZE_CNT-1:0]  o_count,
  output logic                 o_overflow,
  output logic                 o_underflow
);

  logic                wr_acc;
  logic                rd_acc;
  logic [SIZE_CNT-1:0] count_q, count_d;
  fifo_flags_t         flags_q, flags_d;
  logic                rd_valid_q, rd_valid_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;

  // Requests are gated by reset and flush so the memory never sees a strobe that the
  // pointers will not follow.
  always_comb begin
    wr_acc = i_rst_n & ~i_clr & i_wr_en & ~flags_q.full;
    rd_acc = i_rst_n & ~i_clr & i_rd_en & ~flags_q.empty;

    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (wr_acc && !rd_acc) begin
      count_d = count_q + SIZE_CNT'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - SIZE_CNT'(1);
    end

    overflow_d  = i_clr ? 1'b0 : (overflow_q  | (i_wr_en & flags_q.full));
    underflow_d = i_clr ? 1'b0 : (underflow_q | (i_rd_en & flags_q.empty));
    rd_valid_d  = rd_acc;

    // Flags track next-count so they line up with o_count without an extra cycle.
    flags_d.full         = (count_d == SIZE_CNT'(SIZE_DEPTH));
    flags_d.empty        = (count_d == '0);
    flags_d.almost_full  = (count_d >= SIZE_CNT'(AF_LEVEL));
    flags_d.almost_empty = (count_d <= SIZE_CNT'(AE_LEVEL));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count_q     <= '0;
      flags_q     <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      flags_q     <= flags_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ptr_wrap #(
    .SIZE_DEPTH (SIZE_DEPTH),
    .SIZE_ADDR  (SIZE_ADDR)
  ) u_wr_ptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_clr),
    .i_adv   (wr_acc),
    .o_ptr   (o_mem_addr_wr)
  );

  fifo_ptr_wrap #(
    .SIZE_DEPTH (SIZE_DEPTH),
    .SIZE_ADDR  (SIZE_ADDR)
  ) u_rd_ptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_clr),
    .i_adv   (rd_acc),
    .o_ptr   (o_mem_addr_rd)
  );

  assign o_mem_wr_en    = wr_acc;
  assign o_mem_rd_en    = rd_acc;
  assign o_rd_valid     = rd_valid_q;
  assign o_full         = flags_q.full;
  assign o_empty        = flags_q.empty;
  assign o_almost_full  = flags_q.almost_full;
  assign o_almost_empty = flags_q.almost_empty;
  assign o_count        = count_q;
  assign o_overflow     = overflow_q;
  assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Bench for fifo_sync_ctrl: vector table, directed corner sequences and random traffic
// checked against an occupancy/modulo-pointer reference model.
module tb_fifo_sync_ctrl;

  localparam int DEPTH = 100;
  localparam int ADDR  = 7;
  localparam int CNT   = 7;
  localparam int AF    = DEPTH - 4;
  localparam int AE    = 4;

  logic            clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            i_wr_en = 1'b0;
  logic            i_rd_en = 1'b0;
  logic            i_clr = 1'b0;
  logic            o_mem_wr_en, o_mem_rd_en, o_rd_valid;
  logic [ADDR-1:0] o_mem_addr_wr, o_mem_addr_rd;
  logic            o_full, o_empty, o_almost_full, o_almost_empty;
  logic [CNT-1:0]  o_count;
  logic            o_overflow, o_underflow;

  always #5 clk = ~clk;

  fifo_sync_ctrl #(.SIZE_DEPTH(DEPTH)) dut (
    .i_clk          (clk),
    .i_rst_n        (i_rst_n),
    .i_wr_en        (i_wr_en),
    .i_rd_en        (i_rd_en),
    .i_clr          (i_clr),
    .o_mem_wr_en    (o_mem_wr_en),
    .o_mem_addr_wr  (o_mem_addr_wr),
    .o_mem_rd_en    (o_mem_rd_en),
    .o_mem_addr_rd  (o_mem_addr_rd),
    .o_rd_valid     (o_rd_valid),
    .o_full         (o_full),
    .o_empty        (o_empty),
    .o_almost_full  (o_almost_full),
    .o_almost_empty (o_almost_empty),
    .o_count        (o_count),
    .o_overflow     (o_overflow),
    .o_underflow    (o_underflow)
  );

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  // Reference model: occupancy plus modulo pointers.
  int m_cnt = 0, m_wp = 0, m_rp = 0;
  bit m_ovf = 0, m_unf = 0, m_rv = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (txn %0d)", name, act, exp, txn);
    end
  endtask

  task automatic step(input bit wr, input bit rd, input bit clr, input bit rstn);
    bit wacc, racc;
    @(negedge clk);
    i_wr_en = wr; i_rd_en = rd; i_clr = clr; i_rst_n = rstn;
    #1;
    wacc = rstn && !clr && wr && (m_cnt < DEPTH);
    racc = rstn && !clr && rd && (m_cnt > 0);
    chk("mem_wr_en", int'(o_mem_wr_en), int'(wacc));
    chk("mem_rd_en", int'(o_mem_rd_en), int'(racc));
    chk("addr_wr", int'(o_mem_addr_wr), m_wp);
    chk("addr_rd", int'(o_mem_addr_rd), m_rp);
    @(posedge clk);
    #1;
    if (!rstn || clr) begin
      m_cnt = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_unf = 0; m_rv = 0;
    end else begin
      if (wr && m_cnt == DEPTH) m_ovf = 1;
      if (rd && m_cnt == 0) m_unf = 1;
      m_cnt = m_cnt + int'(wacc) - int'(racc);
      if (wacc) m_wp = (m_wp + 1) % DEPTH;
      if (racc) m_rp = (m_rp + 1) % DEPTH;
      m_rv = racc;
    end
    txn++;
    chk("count", int'(o_count), m_cnt);
    chk("empty", int'(o_empty), int'(m_cnt == 0));
    chk("full", int'(o_full), int'(m_cnt == DEPTH));
    chk("almost_full", int'(o_almost_full), int'(m_cnt >= AF));
    chk("almost_empty", int'(o_almost_empty), int'(m_cnt <= AE));
    chk("overflow", int'(o_overflow), int'(m_ovf));
    chk("underflow", int'(o_underflow), int'(m_unf));
    chk("rd_valid", int'(o_rd_valid), int'(m_rv));
    chk("full_and_empty", int'(o_full && o_empty), 0);
    $display("txn %0d wr=%0b rd=%0b clr=%0b rst_n=%0b -> count=%0d wa=%0d ra=%0d rv=%0b ovf=%0b unf=%0b",
             txn, wr, rd, clr, rstn, o_count, o_mem_addr_wr, o_mem_addr_rd, o_rd_valid,
             o_overflow, o_underflow);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
  endtask

  typedef struct {
    bit wr, rd, clr, rstn;
    int cnt;
    bit empty, full, ovf, unf, rv;
  } vec_t;

  vec_t vecs[10];

  initial begin
    //          wr rd clr rstn cnt empty full ovf unf rv
    vecs[0] = '{0, 0, 0, 0,   0,  1,    0,   0,  0,  0};
    vecs[1] = '{1, 0, 0, 1,   1,  0,    0,   0,  0,  0};
    vecs[2] = '{1, 1, 0, 1,   1,  0,    0,   0,  0,  1};
    vecs[3] = '{0, 1, 0, 1,   0,  1,    0,   0,  0,  1};
    vecs[4] = '{0, 1, 0, 1,   0,  1,    0,   0,  1,  0};
    vecs[5] = '{1, 1, 0, 1,   1,  0,    0,   0,  1,  0};
    vecs[6] = '{1, 0, 1, 1,   0,  1,    0,   0,  0,  0};
    vecs[7] = '{1, 0, 0, 1,   1,  0,    0,   0,  0,  0};
    vecs[8] = '{1, 0, 0, 0,   0,  1,    0,   0,  0,  0};
    vecs[9] = '{0, 1, 0, 1,   0,  1,    0,   0,  1,  0};

    // Reset and idle
    do_reset();
    step(0, 0, 0, 1);
    chk("idle_empty", int'(o_empty), 1);
    chk("idle_count", int'(o_count), 0);
    chk("idle_full", int'(o_full), 0);
    chk("idle_addr_wr", int'(o_mem_addr_wr), 0);

    // Vector table
    for (int v = 0; v < 10; v++) begin
      step(vecs[v].wr, vecs[v].rd, vecs[v].clr, vecs[v].rstn);
      chk("vec_count", int'(o_count), vecs[v].cnt);
      chk("vec_empty", int'(o_empty), int'(vecs[v].empty));
      chk("vec_full", int'(o_full), int'(vecs[v].full));
      chk("vec_ovf", int'(o_overflow), int'(vecs[v].ovf));
      chk("vec_unf", int'(o_underflow), int'(vecs[v].unf));
      chk("vec_rv", int'(o_rd_valid), int'(vecs[v].rv));
    end

    // Fill to full, almost-full threshold, overflow
    do_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1, 0, 0, 1);
      if (i == 95) chk("af_at_95", int'(o_almost_full), 0);
      if (i == 96) chk("af_at_96", int'(o_almost_full), 1);
    end
    chk("fill_count", int'(o_count), 100);
    chk("fill_full", int'(o_full), 1);
    step(1, 0, 0, 1);
    chk("ovf_set", int'(o_overflow), 1);
    chk("ovf_count", int'(o_count), 100);

    // Wrap-around: write 100, read 60, write 50
    do_reset();
    for (int i = 0; i < 100; i++) step(1, 0, 0, 1);
    chk("wrap_wa0", int'(o_mem_addr_wr), 0);
    for (int i = 0; i < 60; i++) step(0, 1, 0, 1);
    for (int i = 0; i < 50; i++) step(1, 0, 0, 1);
    chk("wrap_wa", int'(o_mem_addr_wr), 50);
    chk("wrap_ra", int'(o_mem_addr_rd), 60);
    chk("wrap_count", int'(o_count), 90);

    // Simultaneous read/write at count 10
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 1);
      chk("rw_rv", int'(o_rd_valid), 1);
      chk("rw_count", int'(o_count), 10);
    end
    chk("rw_wa", int'(o_mem_addr_wr), 30);
    chk("rw_ra", int'(o_mem_addr_rd), 20);

    // Mid-operation flush at count 37 with errors set
    do_reset();
    step(0, 1, 0, 1);
    for (int i = 0; i < 37; i++) step(1, 0, 0, 1);
    chk("pre_clr_count", int'(o_count), 37);
    chk("pre_clr_unf", int'(o_underflow), 1);
    step(1, 0, 1, 1);
    chk("clr_count", int'(o_count), 0);
    chk("clr_empty", int'(o_empty), 1);
    chk("clr_unf", int'(o_underflow), 0);
    chk("clr_wa", int'(o_mem_addr_wr), 0);

    // Random traffic with varying fill bias, occasional flush and reset
    do_reset();
    for (int blk = 0; blk < 8; blk++) begin
      int pw;
      pw = (blk % 2 == 0) ? int'($urandom_range(70, 95)) : int'($urandom_range(5, 30));
      for (int i = 0; i < 200; i++) begin
        bit wr, rd, clr, rstn;
        wr   = ($urandom_range(99) < pw);
        rd   = ($urandom_range(99) < (100 - pw));
        clr  = ($urandom_range(299) == 0);
        rstn = ($urandom_range(399) != 0);
        step(wr, rd, clr, rstn);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
